// File: rtl/deb_pkg.sv
// Shared types and default constants for the four-channel switch debouncer.
package deb_pkg;

   typedef enum logic {
      STABLE = 1'b0,
      CHECK  = 1'b1
   } deb_state_e;

   localparam int unsigned DEB_N_CH          = 4;
   localparam int unsigned DEB_CNT_W         = 16;
   localparam int unsigned DEB_STABLE_CYCLES = 50000;
   localparam int unsigned DEB_SYNC_STAGES   = 2;
   // Short stability window so simulations finish quickly
   localparam int unsigned DEB_SIM_CYCLES    = 8;

endpackage : deb_pkg

// File: rtl/switch_debounce4_if.sv
// Switch-side and conditioned-output bundle of the debouncer.
interface switch_debounce4_if #(
   parameter int unsigned N_CH = 4
) ();

   logic [N_CH-1:0] sw_in;
   logic [N_CH-1:0] sw_out;
   logic [N_CH-1:0] rise_pulse;
   logic [N_CH-1:0] fall_pulse;
   logic            settled;

   modport master (
      output sw_in,
      input  sw_out, rise_pulse, fall_pulse, settled
   );

   modport slave (
      input  sw_in,
      output sw_out, rise_pulse, fall_pulse, settled
   );

endinterface : switch_debounce4_if

// File: rtl/debounce_ch.sv
// One debounce channel: synchroniser, STABLE/CHECK FSM, stability counter, edge pulses.
module debounce_ch
   import deb_pkg::*;
#(
   parameter int unsigned CNT_W         = DEB_CNT_W,
   parameter int unsigned STABLE_CYCLES = DEB_STABLE_CYCLES,
   parameter int unsigned SYNC_STAGES   = DEB_SYNC_STAGES
) (
   input  logic clk,
   input  logic rst,
   input  logic sw_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o,
   output logic stable_o
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s;
   deb_state_e             state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   level_q, level_d;
   logic                   rise_q, rise_d;
   logic                   fall_q, fall_d;

   assign s = sync_q[SYNC_STAGES-1];

   // Plain flop chain, nothing between stages
   always_ff @(posedge clk) begin
      if (rst) sync_q <= '0;
      else     sync_q <= {sync_q[SYNC_STAGES-2:0], sw_i};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= STABLE;
         cnt_q   <= '0;
         level_q <= 1'b0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         level_q <= level_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      level_d = level_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      case (state_q)
         STABLE: begin
            if (s != level_q) begin
               state_d = CHECK;
               cnt_d   = CNT_W'(1);
            end else begin
               cnt_d   = '0;
            end
         end
         CHECK: begin
            if (s == level_q) begin
               state_d = STABLE;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               // New level held long enough: accept it and flag the edge
               level_d = s;
               rise_d  = s;
               fall_d  = ~s;
               state_d = STABLE;
               cnt_d   = '0;
            end else begin
               cnt_d   = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = STABLE;
            cnt_d   = '0;
         end
      endcase
   end

   assign level_o  = level_q;
   assign rise_o   = rise_q;
   assign fall_o   = fall_q;
   assign stable_o = (state_q == STABLE);

endmodule : debounce_ch

// File: rtl/switch_debounce4.sv
// Four-switch conditioner feeding the F1/F2 block's A-D inputs; DEB_TOGGLE_EN makes
// each output a push-button latch instead of the debounced level.
module switch_debounce4
   import deb_pkg::*;
#(
   parameter int unsigned N_CH          = DEB_N_CH,
   parameter int unsigned CNT_W         = DEB_CNT_W,
   parameter int unsigned STABLE_CYCLES = DEB_STABLE_CYCLES,
   parameter int unsigned SYNC_STAGES   = DEB_SYNC_STAGES
) (
   input logic               clk,
   input logic               rst,
   switch_debounce4_if.slave bus
);

   localparam int unsigned        WARM_W    = $clog2(SYNC_STAGES + 1);
   localparam logic [WARM_W-1:0]  WARM_DONE = WARM_W'(SYNC_STAGES);

   if (STABLE_CYCLES < 2 || 64'(STABLE_CYCLES) > ((64'd1 << CNT_W) - 64'd1) ||
       SYNC_STAGES < 2) begin : g_bad_param
      $error("switch_debounce4: STABLE_CYCLES or SYNC_STAGES out of legal range");
   end

   logic [N_CH-1:0]   level;
   logic [N_CH-1:0]   rise;
   logic [N_CH-1:0]   fall;
   logic [N_CH-1:0]   stable;
   logic [WARM_W-1:0] warm_q, warm_d;
   logic              settled_q, settled_d;

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      debounce_ch #(
         .CNT_W        (CNT_W),
         .STABLE_CYCLES(STABLE_CYCLES),
         .SYNC_STAGES  (SYNC_STAGES)
      ) u_ch (
         .clk     (clk),
         .rst     (rst),
         .sw_i    (bus.sw_in[i]),
         .level_o (level[i]),
         .rise_o  (rise[i]),
         .fall_o  (fall[i]),
         .stable_o(stable[i])
      );
   end

   // Warm-up counter saturates once the synchroniser has flushed
   always_comb begin
      warm_d    = (warm_q == WARM_DONE) ? warm_q : warm_q + WARM_W'(1);
      settled_d = (warm_q == WARM_DONE) && (&stable);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         warm_q    <= '0;
         settled_q <= 1'b0;
      end else begin
         warm_q    <= warm_d;
         settled_q <= settled_d;
      end
   end

`ifdef DEB_TOGGLE_EN
   logic [N_CH-1:0] tog_q, tog_d;

   assign tog_d = tog_q ^ rise;

   always_ff @(posedge clk) begin
      if (rst) tog_q <= '0;
      else     tog_q <= tog_d;
   end

   assign bus.sw_out = tog_q;
`else
   assign bus.sw_out = level;
`endif

   assign bus.rise_pulse = rise;
   assign bus.fall_pulse = fall;
   assign bus.settled    = settled_q;

endmodule : switch_debounce4

// File: tb/tb_switch_debounce4.sv
// Directed plus random bench for switch_debounce4 against a sliding-window reference model.
module tb_switch_debounce4;
   import deb_pkg::*;

   localparam int unsigned N  = 4;
   localparam int unsigned SC = DEB_SIM_CYCLES;
   localparam int unsigned SS = DEB_SYNC_STAGES;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   switch_debounce4_if #(.N_CH(N)) bus ();

   switch_debounce4 #(
      .N_CH         (N),
      .CNT_W        (16),
      .STABLE_CYCLES(SC),
      .SYNC_STAGES  (SS)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: a channel accepts a level once its last SC synchronised samples all disagree with it
   logic [N-1:0]  m_pipe [SS];
   logic [SC-1:0] m_hist [N];
   logic [N-1:0]  m_lvl, m_tog, m_rise, m_fall, m_busy;
   logic          m_settled;
   int            m_rel;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_edge();
      logic [N-1:0] s;
      s = m_pipe[SS-1];
      if (rst) begin
         for (int k = 0; k < SS; k++) m_pipe[k] = '0;
         for (int i = 0; i < N; i++) m_hist[i] = '0;
         m_lvl = '0; m_tog = '0; m_rise = '0; m_fall = '0; m_busy = '0;
         m_settled = 1'b0;
         m_rel = 0;
      end else begin
         m_settled = (m_rel >= SS) && (m_busy == '0);
         if (m_rel < SS) m_rel++;
         m_tog = m_tog ^ m_rise;
         for (int k = SS - 1; k > 0; k--) m_pipe[k] = m_pipe[k-1];
         m_pipe[0] = bus.sw_in;
         m_rise = '0;
         m_fall = '0;
         for (int i = 0; i < N; i++) begin
            m_hist[i] = {m_hist[i][SC-2:0], s[i]};
            if (m_hist[i] == {SC{~m_lvl[i]}}) begin
               m_lvl[i] = ~m_lvl[i];
               if (m_lvl[i]) m_rise[i] = 1'b1;
               else          m_fall[i] = 1'b1;
            end
            m_busy[i] = (s[i] != m_lvl[i]);
         end
      end
   endtask

   task automatic step(input int n);
      logic [N-1:0] exp_out;
      for (int c = 0; c < n; c++) begin
         @(posedge clk);
         model_edge();
         #1;
`ifdef DEB_TOGGLE_EN
         exp_out = m_tog;
`else
         exp_out = m_lvl;
`endif
         chk("sw_out",     32'(bus.sw_out),     32'(exp_out));
         chk("rise_pulse", 32'(bus.rise_pulse), 32'(m_rise));
         chk("fall_pulse", 32'(bus.fall_pulse), 32'(m_fall));
         chk("settled",    32'(bus.settled),    32'(m_settled));
      end
   endtask

   initial begin
      int n_r;
      m_rel = 0;
      rst = 1'b1;
      bus.sw_in = 4'hF;

      // Reset held with all switches high
      step(3);
      chk("rst_sw_out", 32'(bus.sw_out), 32'h0);
      chk("rst_settled", 32'(bus.settled), 32'h0);
      rst = 1'b0;
      step(3);
      chk("warm_settled_hi", 32'(bus.settled), 32'h1);
      step(1);
      chk("warm_settled_drop", 32'(bus.settled), 32'h0);
      step(5);
      chk("rel_rise_early", 32'(bus.rise_pulse), 32'h0);
      step(1);
      chk("rel_rise_all", 32'(bus.rise_pulse), 32'hF);
      bus.sw_in = 4'h0;
      step(20);

      // Clean step on channel 0
      bus.sw_in[0] = 1'b1;
      step(9);
      chk("step_rise_early", 32'(bus.rise_pulse[0]), 32'h0);
      step(1);
      chk("step_rise", 32'(bus.rise_pulse[0]), 32'h1);
      step(1);
      chk("step_rise_one_cycle", 32'(bus.rise_pulse[0]), 32'h0);

      // Bounce on channel 1, then a final settle high
      for (int c = 0; c < 40; c++) begin
         if (c % 3 == 0) bus.sw_in[1] = ~bus.sw_in[1];
         step(1);
         chk("bounce_no_rise", 32'(bus.rise_pulse[1]), 32'h0);
      end
      bus.sw_in[1] = 1'b1;
      step(9);
      chk("bounce_rise_early", 32'(bus.rise_pulse[1]), 32'h0);
      step(1);
      chk("bounce_rise", 32'(bus.rise_pulse[1]), 32'h1);

      // All four channels switching together
      bus.sw_in = 4'h0;
      step(12);
      bus.sw_in = 4'hF;
      step(9);
      chk("simul_rise_early", 32'(bus.rise_pulse), 32'h0);
      step(1);
      chk("simul_rise", 32'(bus.rise_pulse), 32'hF);

      // Reset five cycles into a check on channel 2
      bus.sw_in = 4'h0;
      step(14);
      bus.sw_in[2] = 1'b1;
      step(SS + 5);
      rst = 1'b1;
      bus.sw_in = 4'h0;
      step(2);
      rst = 1'b0;
      step(3);
      chk("midchk_settled", 32'(bus.settled), 32'h1);
      chk("midchk_sw_out", 32'(bus.sw_out), 32'h0);
      step(12);
      chk("midchk_no_change", 32'(bus.sw_out), 32'h0);

      // Two clean presses on channel 3
      n_r = 0;
      for (int c = 0; c < 48; c++) begin
         bus.sw_in[3] = ((c / 12) % 2 == 0);
         step(1);
         if (bus.rise_pulse[3]) n_r++;
      end
      chk("press_rise_count", 32'(n_r), 32'd2);

      // Random bouncing with occasional resets
      for (int c = 0; c < 1200; c++) begin
         for (int i = 0; i < N; i++)
            if ($urandom_range(0, 9) == 0) bus.sw_in[i] = ~bus.sw_in[i];
         rst = ($urandom_range(0, 299) == 0);
         step(1);
      end
      rst = 1'b0;
      step(15);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_switch_debounce4
